pipe_stage_reg: RTL and testbench

- Parametrised successor to the fixed MEM/WB stage register.
- One generic stage register for any boundary (F/D, D/E, E/M, M/W) of the 5-stage MIPS pipeline.
- Carries instruction, PC, control word and N 32-bit data channels under a valid/ready handshake with a one-entry skid buffer, plus flush and optional saturating TNew decrement.
- Replaces the per-stage hand-written registers.

---
 rtl/pipe_stage_reg_pkg.sv | 12 +
 rtl/pipe_stage_reg_entry.sv | 27 ++
 rtl/pipe_stage_reg.sv | 58 +++++
 tb/tb_pipe_stage_reg.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared control-word layout, reset PC and entry width helper
package pipe_stage_reg_pkg;
  localparam int CTRL_LEN = 31;
  localparam int MEMWRITE_BIT = 30;
  localparam int REGWRITE_BIT = 29;
  localparam int TNEW_LSB = 8;
  localparam int CMPOP_LSB = 0;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  function automatic int entry_width(input int n_data, input int ctrl_len);
    return 64 + ctrl_len + 32 * n_data;
  endfunction
endpackage

// File: rtl/pipe_stage_reg_entry.sv
// stage_entry_reg: one valid+payload register with load, clear and async reset; pc lives in bits [31:0]
module stage_entry_reg #(
  parameter int W = 96,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clear,
  input  logic         load,
  input  logic         d_valid,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);
  localparam logic [W-1:0] INIT = W'(RESET_PC);
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      valid <= 1'b0;
      q <= INIT;
    end else if (clear) begin
      valid <= 1'b0;
      q <= INIT;
    end else if (load) begin
      valid <= d_valid;
      if (d_valid) q <= d;
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline stage register with skid buffer, flush and TNew decrement
module pipe_stage_reg #(
  parameter int CTRL_LEN = pipe_stage_reg_pkg::CTRL_LEN,
  parameter int N_DATA = 3,
  parameter int TNEW_LSB = pipe_stage_reg_pkg::TNEW_LSB,
  parameter int DEC_TNEW = 1,
  parameter logic [31:0] RESET_PC = pipe_stage_reg_pkg::RESET_PC
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Flush,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [31:0]           InsIn,
  input  logic [31:0]           PCIn,
  input  logic [CTRL_LEN-1:0]   CtrlIn,
  input  logic [N_DATA*32-1:0]  DataIn,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [31:0]           InsOut,
  output logic [31:0]           PCOut,
  output logic [CTRL_LEN-1:0]   CtrlOut,
  output logic [N_DATA*32-1:0]  DataOut
);
  import pipe_stage_reg_pkg::*;
  localparam int W = entry_width(N_DATA, CTRL_LEN);
  logic [W-1:0] in_e, main_q, skid_q;
  logic main_valid, skid_valid, accept, pop, main_free;
  logic [CTRL_LEN-1:0] ctrl_raw, ctrl_adj;
  logic [2:0] t;
  assign in_e = {DataIn, CtrlIn, InsIn, PCIn};
  assign InReady = !skid_valid;
  assign accept = InValid && InReady;
  assign pop = main_valid && OutReady;
  assign main_free = !main_valid || pop;
  stage_entry_reg #(.W(W), .RESET_PC(RESET_PC)) u_main (
    .Clk(Clk), .Reset(Reset), .clear(Flush), .load(main_free),
    .d_valid(skid_valid || accept), .d(skid_valid ? skid_q : in_e),
    .valid(main_valid), .q(main_q)
  );
  stage_entry_reg #(.W(W), .RESET_PC(RESET_PC)) u_skid (
    .Clk(Clk), .Reset(Reset), .clear(Flush),
    .load(main_free ? skid_valid : accept),
    .d_valid(accept), .d(in_e),
    .valid(skid_valid), .q(skid_q)
  );
  always_comb begin
    ctrl_raw = main_q[64 +: CTRL_LEN];
    t = ctrl_raw[TNEW_LSB +: 3];
    ctrl_adj = ctrl_raw;
    ctrl_adj[TNEW_LSB +: 3] = (DEC_TNEW != 0 && t != 3'd0) ? t - 3'd1 : t;
    OutValid = main_valid;
    PCOut = main_q[31:0];
    InsOut = main_valid ? main_q[63:32] : '0;
    CtrlOut = main_valid ? ctrl_adj : '0;
    DataOut = main_valid ? main_q[64+CTRL_LEN +: 32*N_DATA] : '0;
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: queue-model bench driving three builds of pipe_stage_reg in lockstep
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;
  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [30:0] ctrl;
    logic [255:0] data;
  } ent_t;
  logic Clk = 1'b0, Reset = 1'b0, Flush = 1'b0, InValid = 1'b0, OutReady = 1'b0;
  logic [31:0] InsIn = '0, PCIn = '0;
  logic [30:0] CtrlIn = '0;
  logic [255:0] din = '0;
  logic r0, v0, ra, va, rb, vb;
  logic [31:0] ins0, pc0, insa, pca, insb, pcb;
  logic [30:0] ctrl0, ctrla, ctrlb;
  logic [95:0] data0;
  logic [31:0] dataa;
  logic [255:0] datab;
  ent_t q[$];
  logic [31:0] last_pc = RESET_PC;
  int checks = 0, errors = 0;
  always #5 Clk = ~Clk;
  pipe_stage_reg dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(r0),
    .InsIn(InsIn), .PCIn(PCIn), .CtrlIn(CtrlIn), .DataIn(din[95:0]),
    .OutValid(v0), .OutReady(OutReady), .InsOut(ins0), .PCOut(pc0), .CtrlOut(ctrl0), .DataOut(data0)
  );
  pipe_stage_reg #(.N_DATA(1), .DEC_TNEW(0)) dut_a (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(ra),
    .InsIn(InsIn), .PCIn(PCIn), .CtrlIn(CtrlIn), .DataIn(din[31:0]),
    .OutValid(va), .OutReady(OutReady), .InsOut(insa), .PCOut(pca), .CtrlOut(ctrla), .DataOut(dataa)
  );
  pipe_stage_reg #(.N_DATA(8)) dut_b (
    .Clk(Clk), .Reset(Reset), .Flush(Flush), .InValid(InValid), .InReady(rb),
    .InsIn(InsIn), .PCIn(PCIn), .CtrlIn(CtrlIn), .DataIn(din),
    .OutValid(vb), .OutReady(OutReady), .InsOut(insb), .PCOut(pcb), .CtrlOut(ctrlb), .DataOut(datab)
  );
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  function automatic logic [30:0] tadj(input logic [30:0] c, input bit dec);
    logic [2:0] tn;
    tn = c[TNEW_LSB +: 3];
    if (dec && tn != 3'd0) c[TNEW_LSB +: 3] = tn - 3'd1;
    return c;
  endfunction
  task automatic cmp_dut(input string nm, input int n, input bit dec, input logic v, input logic r,
                         input logic [31:0] ins, input logic [31:0] pc, input logic [30:0] ctrl,
                         input logic [255:0] data);
    bit ev;
    logic [255:0] mask;
    ev = q.size() > 0;
    mask = (256'd1 << (32 * n)) - 256'd1;
    chk({nm, ".valid"}, 256'(v), 256'(ev));
    chk({nm, ".ready"}, 256'(r), 256'(q.size() < 2));
    chk({nm, ".ins"}, 256'(ins), ev ? 256'(q[0].ins) : 256'd0);
    chk({nm, ".pc"}, 256'(pc), ev ? 256'(q[0].pc) : 256'(last_pc));
    chk({nm, ".ctrl"}, 256'(ctrl), ev ? 256'(tadj(q[0].ctrl, dec)) : 256'd0);
    chk({nm, ".data"}, data, ev ? (q[0].data & mask) : 256'd0);
  endtask
  always @(posedge Clk or negedge Reset) begin : model
    bit pop, acc;
    if (!Reset) begin
      q.delete();
      last_pc = RESET_PC;
    end else if (Flush) begin
      q.delete();
      last_pc = RESET_PC;
    end else begin
      pop = q.size() > 0 && OutReady;
      acc = InValid && q.size() < 2;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{InsIn, PCIn, CtrlIn, din});
      if (q.size() > 0) last_pc = q[0].pc;
    end
  end
  always @(negedge Clk) begin
    cmp_dut("d3", 3, 1'b1, v0, r0, ins0, pc0, ctrl0, 256'(data0));
    cmp_dut("d1", 1, 1'b0, va, ra, insa, pca, ctrla, 256'(dataa));
    cmp_dut("d8", 8, 1'b1, vb, rb, insb, pcb, ctrlb, datab);
  end
  task automatic step(input bit v, input bit r, input bit f, input int id, input logic [2:0] tn);
    logic [30:0] c;
    c = 31'h1234_5678 ^ 31'(id * 32'h0101_0101);
    c[TNEW_LSB +: 3] = tn;
    c[CMPOP_LSB +: 3] = 3'(id);
    c[MEMWRITE_BIT] = id[0];
    c[REGWRITE_BIT] = 1'b1;
    InValid = v;
    OutReady = r;
    Flush = f;
    InsIn = 32'h2400_0000 + 32'(id);
    PCIn = 32'h3000 + 32'(4 * id);
    CtrlIn = c;
    for (int k = 0; k < 8; k++) din[32*k +: 32] = 32'hA5A5_0000 + 32'(id * 256 + k);
    @(posedge Clk);
    #2;
  endtask
  initial begin
    #17;
    chk("rst.valid", 256'(v0), 256'd0);
    chk("rst.pc", 256'(pc0), 256'h3000);
    chk("rst.ready", 256'(r0), 256'd1);
    Reset = 1'b1;
    step(1, 1, 0, 0, 3'd2);
    chk("s0.valid", 256'(v0), 256'd1);
    chk("s0.pc", 256'(pc0), 256'h3000);
    chk("s0.tnew", 256'(ctrl0[10:8]), 256'd1);
    chk("s0.tnew_nodec", 256'(ctrla[10:8]), 256'd2);
    step(1, 1, 0, 1, 3'd0);
    chk("s1.pc", 256'(pc0), 256'h3004);
    chk("s1.tnew", 256'(ctrl0[10:8]), 256'd0);
    step(1, 1, 0, 2, 3'd5);
    chk("s2.ready", 256'(r0), 256'd1);
    chk("s2.tnew", 256'(ctrl0[10:8]), 256'd4);
    step(1, 1, 0, 3, 3'd1);
    chk("s3.pc", 256'(pc0), 256'h300C);
    chk("s3.d8ch7", 256'(datab[255:224]), 256'hA5A5_0307);
    chk("s3.d1ch0", 256'(dataa), 256'hA5A5_0300);
    chk("s3.d3ch2", 256'(data0[95:64]), 256'hA5A5_0302);
    step(0, 1, 0, 0, 3'd0);
    step(1, 0, 0, 4, 3'd3);
    step(1, 0, 0, 5, 3'd3);
    chk("stall.ready", 256'(r0), 256'd0);
    step(1, 0, 0, 6, 3'd3);
    chk("stall.pc", 256'(pc0), 256'h3010);
    chk("stall.tnew", 256'(ctrl0[10:8]), 256'd2);
    step(1, 1, 0, 6, 3'd3);
    chk("rel.pc", 256'(pc0), 256'h3014);
    step(1, 1, 0, 6, 3'd3);
    chk("rel2.pc", 256'(pc0), 256'h3018);
    step(0, 1, 0, 0, 3'd0);
    chk("drain.valid", 256'(v0), 256'd0);
    chk("drain.pc", 256'(pc0), 256'h3018);
    step(1, 0, 0, 7, 3'd2);
    step(1, 0, 0, 8, 3'd2);
    step(1, 0, 1, 9, 3'd2);
    chk("flush.valid", 256'(v0), 256'd0);
    chk("flush.ctrl", 256'(ctrl0), 256'd0);
    chk("flush.pc", 256'(pc0), 256'h3000);
    chk("flush.ready", 256'(r0), 256'd1);
    step(0, 1, 0, 0, 3'd0);
    chk("flush.gone", 256'(v0), 256'd0);
    step(1, 0, 0, 10, 3'd2);
    step(1, 0, 0, 11, 3'd2);
    #1 Reset = 1'b0;
    #1;
    chk("arst.valid", 256'(v0), 256'd0);
    chk("arst.ins", 256'(ins0), 256'd0);
    chk("arst.pc", 256'(pc0), 256'h3000);
    chk("arst.ready", 256'(r0), 256'd1);
    #2 Reset = 1'b1;
    step(1, 1, 0, 12, 3'd3);
    chk("post.valid", 256'(v0), 256'd1);
    chk("post.pc", 256'(pc0), 256'h3030);
    chk("post.tnew", 256'(ctrl0[10:8]), 256'd2);
    step(0, 1, 0, 0, 3'd0);
    step(0, 1, 0, 0, 3'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
